hs_rr_arbiter: RTL and testbench
================================

HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesting 4-phase channels (legal 2..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop depth of every input synchronizer (legal >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_req  input  N  per-requester 4-phase request, asynchronous to clk.
REQ-006 SHALL have port in_ack  output  N  per-requester acknowledge, registered.
REQ-007 SHALL have port in_dat  input  N  per-requester bundled data bit, stable while in_req[i]=1.
REQ-008 SHALL have port out_req  output  1  shared-channel request, registered.
REQ-009 SHALL have port out_ack  input  1  shared-channel acknowledge, asynchronous to clk.
REQ-010 SHALL have port out_dat  output  1  shared-channel data, registered, stable while out_req=1.
REQ-011 SHALL have port grant  output  N  one-hot current winner, all-zero when idle.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port xfer_cnt  output  8  count of completed transfers.

Function
REQ-014 SHALL pass each in_req bit and out_ack through its own SYNC_STAGES-deep synchronizer; all control decisions SHALL use synchronized values only.
REQ-015 SHALL implement states IDLE, FWD, DRAIN, encoded in registers.
REQ-016 IDLE: if any synchronized in_req is high, SHALL select winner w by round-robin, searching from index ptr+1 upward modulo N; on the same edge set grant[w]=1, out_dat=in_dat[w], out_req=1, go to FWD.
REQ-017 IDLE with no synchronized request SHALL hold all outputs and remain in IDLE.
REQ-018 FWD: on synchronized out_ack=1 SHALL set in_ack[w]=1 and out_req=0 on the same edge, go to DRAIN; otherwise hold.
REQ-019 DRAIN: when synchronized out_ack=0 and synchronized in_req[w]=0 (either order, any delay), SHALL set in_ack[w]=0, grant=0, ptr=w, increment xfer_cnt, and go to IDLE on the same edge.
REQ-020 out_dat SHALL change only on entry to FWD; it SHALL hold its value in DRAIN and IDLE.
REQ-021 Latency: out_req SHALL rise no later than SYNC_STAGES+1 clk edges after in_req[w] rises with the block IDLE; in_ack[w] SHALL rise no later than SYNC_STAGES+1 edges after out_ack rises.
REQ-022 At most one in_ack bit and one grant bit SHALL be high at any time; in_ack[i] SHALL be high only while grant[i]=1.
REQ-023 Requests arriving during FWD or DRAIN SHALL not affect w; they SHALL be arbitrated at the next IDLE.
REQ-024 Simultaneous requests SHALL be resolved solely by the round-robin order of REQ-016; a requester dropping in_req before being granted SHALL simply not be selected.
REQ-025 xfer_cnt SHALL wrap 255 -> 0 without any flag.
REQ-026 A new transfer SHALL start no sooner than one edge after returning to IDLE (no IDLE bypass).

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, out_req=0, out_dat=0, in_ack=0, grant=0, busy=0, xfer_cnt=0, all synchronizer flops=0, ptr=N-1 (requester 0 has first priority).
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer with no count increment; the environment is responsible for restarting its handshakes after release.
REQ-029 After rst_n rises, the first arbitration SHALL occur no earlier than SYNC_STAGES edges later.

Verification
REQ-030 Reset: hold rst_n=0 with in_req=4'b1111 -> all outputs 0; release -> grant=4'b0001 first.
REQ-031 Single: in_req[2]=1, in_dat[2]=1, responder acks -> out_req high within 3 edges, out_dat=1, in_ack[2] high within 3 edges of out_ack, after both return to zero xfer_cnt=1, grant=0.
REQ-032 Simultaneous: in_req[0] and in_req[3] rise same cycle from reset -> served in order 0 then 3; grant never multi-hot.
REQ-033 Fairness: all four requesters re-request immediately after each ack low -> grant sequence 0,1,2,3,0,1 with no starvation.
REQ-034 Reset during DRAIN (in_ack[1]=1) -> in_ack, out_req, grant all 0 asynchronously, xfer_cnt=0; next transfer starts at requester 0.
REQ-035 Wrap: 256 completed transfers -> xfer_cnt=0; 257th -> xfer_cnt=1.

Source files
------------

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin arbiter merging N 4-phase handshake channels onto one shared channel.
module hs_rr_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_req,
  output logic [N-1:0] in_ack,
  input  logic [N-1:0] in_dat,
  output logic         out_req,
  input  logic         out_ack,
  output logic         out_dat,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic [7:0]   xfer_cnt
);
  localparam int PW = $clog2(N);
  typedef enum logic [1:0] {IDLE, FWD, DRAIN} state_t;
  state_t                           state;
  logic [SYNC_STAGES-1:0][N-1:0]    req_sr;
  logic [SYNC_STAGES-1:0]           ack_sr;
  logic [N-1:0]                     req_s;
  logic                             ack_s;
  logic [PW-1:0]                    ptr, w, win, idx;
  assign req_s = req_sr[SYNC_STAGES-1];
  assign ack_s = ack_sr[SYNC_STAGES-1];
  assign busy  = (state != IDLE);
  // descending scan so the nearest requester after ptr is the last one written
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req_s[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sr   <= '0;
      ack_sr   <= '0;
      state    <= IDLE;
      out_req  <= 1'b0;
      out_dat  <= 1'b0;
      in_ack   <= '0;
      grant    <= '0;
      xfer_cnt <= '0;
      ptr      <= PW'(N - 1);
      w        <= '0;
    end else begin
      req_sr <= {req_sr[SYNC_STAGES-2:0], in_req};
      ack_sr <= {ack_sr[SYNC_STAGES-2:0], out_ack};
      case (state)
        IDLE: if (|req_s) begin
          w       <= win;
          grant   <= N'(1) << win;
          out_dat <= in_dat[win];
          out_req <= 1'b1;
          state   <= FWD;
        end
        FWD: if (ack_s) begin
          in_ack[w] <= 1'b1;
          out_req   <= 1'b0;
          state     <= DRAIN;
        end
        DRAIN: if (!ack_s && !req_s[w]) begin
          in_ack   <= '0;
          grant    <= '0;
          ptr      <= w;
          xfer_cnt <= xfer_cnt + 8'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter: randomized handshake traffic checked against a round-robin reference model.
module tb_hs_rr_arbiter;
  localparam int N = 4;
  localparam int S = 2;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_req = '0;
  logic [N-1:0] in_dat = '0;
  logic         out_ack = 1'b0;
  logic [N-1:0] in_ack, grant;
  logic         out_req, out_dat, busy;
  logic [7:0]   xfer_cnt;
  int           vectors = 0;
  int           miscompares = 0;
  logic [N-1:0] pend = '0;
  int           ptr_m = N - 1;
  int           cnt_m = 0;
  bit           refill = 1'b0;

  hs_rr_arbiter #(.N(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_ack(in_ack), .in_dat(in_dat),
    .out_req(out_req), .out_ack(out_ack), .out_dat(out_dat), .grant(grant),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // first pending requester after the last served one, wrapping modulo N
  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) if (pend[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  task automatic wait_for(input int sel, output int n);
    n = 0;
    while (!(sel == 0 ? out_req === 1'b1 : sel == 1 ? |in_ack === 1'b1 : grant === '0) && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic transfer();
    int w, n;
    logic [N-1:0] oh, nr;
    logic d;
    bit ack_first;
    if (pend == '0) begin
      nr = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (nr[i]) in_dat[i] = 1'($urandom);
      in_req = nr;
      pend = nr;
    end
    w  = rr_pick();
    oh = N'(1) << w;
    d  = in_dat[w];
    wait_for(0, n);
    chk("out_req_latency", 32'(n <= S + 1), 1);
    chk("grant", grant, oh);
    chk("out_dat", out_dat, d);
    chk("busy_fwd", busy, 1);
    chk("in_ack_fwd", in_ack, 0);
    if (!refill)
      for (int i = 0; i < N; i++)
        if (i != w && $urandom_range(0, 3) == 0) begin
          if (pend[i]) begin
            pend[i] = 1'b0;
            in_req[i] = 1'b0;
          end else begin
            in_dat[i] = 1'($urandom);
            pend[i] = 1'b1;
            in_req[i] = 1'b1;
          end
        end
    repeat ($urandom_range(S + 1, S + 4)) tick();
    chk("hold_fwd", {out_req, grant, in_ack}, {1'b1, oh, {N{1'b0}}});
    out_ack = 1'b1;
    wait_for(1, n);
    chk("in_ack_latency", 32'(n <= S + 1), 1);
    chk("in_ack", in_ack, oh);
    chk("out_req_fall", out_req, 0);
    chk("out_dat_drain", out_dat, d);
    ack_first = 1'($urandom);
    if (ack_first) out_ack = 1'b0; else in_req[w] = 1'b0;
    repeat ($urandom_range(S + 2, S + 4)) tick();
    chk("drain_hold", {grant, in_ack}, {oh, oh});
    if (ack_first) in_req[w] = 1'b0; else out_ack = 1'b0;
    pend[w] = 1'b0;
    ptr_m = w;
    cnt_m = (cnt_m + 1) % 256;
    wait_for(2, n);
    chk("drain_timeout", 32'(n < 40), 1);
    chk("xfer_cnt", xfer_cnt, cnt_m);
    chk("idle_busy", busy, 0);
    chk("idle_ack", in_ack, 0);
    chk("idle_out_dat", out_dat, d);
    if (refill) begin
      in_dat[w] = 1'($urandom);
      in_req[w] = 1'b1;
      pend[w] = 1'b1;
    end
  endtask

  initial begin
    int n;
    in_req = '1;
    in_dat = 4'b0101;
    pend = '1;
    repeat (3) tick();
    chk("reset_outputs", {in_ack, grant, out_req, out_dat, busy, xfer_cnt}, 0);
    rst_n = 1'b1;
    wait_for(0, n);
    chk("reset_first_latency", n, S + 1);
    chk("reset_first_grant", grant, 1);
    repeat (40) transfer();
    wait_for(0, n);
    out_ack = 1'b1;
    wait_for(1, n);
    chk("pre_reset_in_ack", 32'(in_ack != '0), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {in_ack, grant, out_req, busy, xfer_cnt}, 0);
    in_req = '0;
    out_ack = 1'b0;
    pend = '0;
    ptr_m = N - 1;
    cnt_m = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    refill = 1'b1;
    for (int i = 0; i < N; i++) in_dat[i] = 1'($urandom);
    in_req = '1;
    pend = '1;
    for (int k = 0; k < 6; k++) begin
      wait_for(0, n);
      chk("fair_grant", grant, 32'(1) << (k % N));
      transfer();
    end
    refill = 1'b0;
    repeat (250) transfer();
    chk("wrap_256", xfer_cnt, 0);
    transfer();
    chk("wrap_257", xfer_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
